interrupter_receiver: RTL

//  Receive end of the interrupter pulse link: takes the raw asynchronous interrupter pulse
//  (fibre/optical input), synchronises it, enforces on-time and off-time safety limits, and

---
 rtl/interrupter_receiver.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/interrupter_receiver.sv
// Receive end of the interrupter pulse link: synchronises the raw pulse, enforces
// on-time / off-time safety limits, drives the bridge gate and measures width/period.
module interrupter_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int MAX_ON_CYCLES  = 500,
  parameter int MIN_OFF_CYCLES = 50000,
  parameter int CNT_W          = 32
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_irq_in,
  input  logic             i_fault_clear,
  output logic             o_gate_out,
  output logic             o_fault_timeout,
  output logic             o_reject_pulse,
  output logic             o_width_valid,
  output logic [CNT_W-1:0] o_pulse_width,
  output logic             o_period_valid,
  output logic [CNT_W-1:0] o_pulse_period
);

  localparam logic [CNT_W-1:0] MAX_ON   = CNT_W'(MAX_ON_CYCLES);
  localparam logic [CNT_W-1:0] MIN_OFF  = CNT_W'(MIN_OFF_CYCLES);
  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ON      = 2'd1,
    ST_BLOCKED = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   w_s;
  logic                   w_rise;
  logic [CNT_W-1:0]       r_on_count;
  logic [CNT_W-1:0]       r_off_count;
  logic [CNT_W-1:0]       r_rise_count;
  logic                   r_ref_valid;
  logic                   w_accept;
  logic                   w_reject;
  logic                   w_timeout;
  logic                   w_width_upd;
  logic                   w_leave_on;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;

  // Input synchroniser plus one-cycle delayed copy for edge detection.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq_in};
      r_s_d  <= w_s;
    end
  end

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and control decode; rises are only evaluated in IDLE.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_timeout    = 1'b0;
    w_width_upd  = 1'b0;
    w_leave_on   = 1'b0;
    if (!i_enable) begin
      w_next_state = ST_IDLE;
      w_leave_on   = (r_state == ST_ON);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            if (!o_fault_timeout && (r_off_count >= MIN_OFF)) begin
              w_accept     = 1'b1;
              w_next_state = ST_ON;
            end else begin
              w_reject     = 1'b1;
              w_next_state = ST_BLOCKED;
            end
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        ST_ON: begin
          if (w_s) begin
            if (r_on_count == MAX_ON) begin
              w_timeout    = 1'b1;
              w_leave_on   = 1'b1;
              w_next_state = ST_BLOCKED;
            end else begin
              w_next_state = ST_ON;
            end
          end else begin
            w_width_upd  = 1'b1;
            w_leave_on   = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
        ST_BLOCKED: begin
          if (!w_s) begin
            w_next_state = ST_IDLE;
          end else begin
            w_next_state = ST_BLOCKED;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // Gate, fault, strobes and measurement counters.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_gate_out      <= 1'b0;
      o_fault_timeout <= 1'b0;
      o_reject_pulse  <= 1'b0;
      o_width_valid   <= 1'b0;
      o_pulse_width   <= '0;
      o_period_valid  <= 1'b0;
      o_pulse_period  <= '0;
      r_on_count      <= '0;
      r_off_count     <= MIN_OFF;
      r_rise_count    <= '0;
      r_ref_valid     <= 1'b0;
    end else begin
      // Enable is folded in so a dropped enable kills the gate on the very next edge.
      o_gate_out     <= (r_state == ST_ON) && i_enable;
      o_reject_pulse <= w_reject;
      o_width_valid  <= w_width_upd;
      o_period_valid <= w_accept && r_ref_valid;

      if (w_timeout) begin
        o_fault_timeout <= 1'b1;
      end else if (i_fault_clear) begin
        o_fault_timeout <= 1'b0;
      end else begin
        o_fault_timeout <= o_fault_timeout;
      end

      if (w_accept) begin
        r_on_count <= ONE;
      end else if ((r_state == ST_ON) && w_s && !w_timeout) begin
        r_on_count <= r_on_count + ONE;
      end else begin
        r_on_count <= r_on_count;
      end

      if (w_width_upd) begin
        o_pulse_width <= r_on_count;
      end else begin
        o_pulse_width <= o_pulse_width;
      end

      if (w_leave_on) begin
        r_off_count <= '0;
      end else if ((r_state != ST_ON) && (r_off_count < MIN_OFF)) begin
        r_off_count <= r_off_count + ONE;
      end else begin
        r_off_count <= r_off_count;
      end

      if (w_accept) begin
        r_rise_count <= ONE;
      end else if (r_rise_count != ALL_ONES) begin
        r_rise_count <= r_rise_count + ONE;
      end else begin
        r_rise_count <= r_rise_count;
      end

      if (w_accept && r_ref_valid) begin
        o_pulse_period <= r_rise_count;
      end else begin
        o_pulse_period <= o_pulse_period;
      end

      if (!i_enable) begin
        r_ref_valid <= 1'b0;
      end else if (w_accept) begin
        r_ref_valid <= 1'b1;
      end else begin
        r_ref_valid <= r_ref_valid;
      end
    end
  end

endmodule
